square: RTL and testbench

SQUARE -- requirements
Module: square

---
 rtl/square.sv | 82 ++++++++
 tb/tb_square.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/square.sv
// Sequential unsigned squarer: a shift-and-add multiplier that handles one operand bit per clock and finishes in WIDTH cycles.
// Optional macro SQUARE_OVF_EN adds an ovf output, set when the square does not fit in WIDTH bits.
module square #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
`ifdef SQUARE_OVF_EN
  output logic               ovf,
`endif
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (operand[count])
      acc_next = acc + ({{WIDTH{1'b0}}, operand} << count);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      operand <= '0;
      acc     <= '0;
      count   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
`ifdef SQUARE_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            operand <= A;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          // The last multiplier bit is folded straight into result on this edge.
          if (count == CW'(WIDTH - 1)) begin
            result <= acc_next;
            done   <= 1'b1;
`ifdef SQUARE_OVF_EN
            ovf    <= |acc_next[2*WIDTH-1:WIDTH];
`endif
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square.sv
// Self-checking bench for square: fixed vectors, random operands against an arithmetic model,
// plus hand-written sequences for ignored start, reset abort and back-to-back restart.
module tb_square;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               busy;
`ifdef SQUARE_OVF_EN
  logic               ovf;
`endif

  square #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (a),
    .result (result),
    .done   (done),
`ifdef SQUARE_OVF_EN
    .ovf    (ovf),
`endif
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full operation from IDLE and check latency, value, pulse width and busy.
  task automatic run_op(input logic [WIDTH-1:0] op, input logic [2*WIDTH-1:0] exp, input string name);
    logic [2*WIDTH-1:0] prev;
    int lat;
    bit moved;
    prev  = result;
    moved = 1'b0;
    lat   = 0;
    a     = op;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = ~op;
    check({name, " busy_after_accept"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin lat = k; break; end
      if (result !== prev) moved = 1'b1;
    end
    check({name, " latency"}, 64'(lat), 64'd16);
    check({name, " result_stable_in_calc"}, 64'(moved), 64'd0);
    check({name, " result"}, 64'(result), 64'(exp));
`ifdef SQUARE_OVF_EN
    check({name, " ovf"}, 64'(ovf), 64'(exp[2*WIDTH-1:WIDTH] != 0));
`endif
    step();
    check({name, " done_one_cycle"}, 64'(done), 64'd0);
    check({name, " busy_cleared"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int pulses;
    int pulse_at[2];
    logic [2*WIDTH-1:0] pulse_res[2];
    logic [WIDTH-1:0] r;

    vecs[0] = '{16'h00E1, 32'h0000C5C1};
    vecs[1] = '{16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 32'h00000000};
    vecs[3] = '{16'h0001, 32'h00000001};
    vecs[4] = '{16'h00FF, 32'h0000FE01};
    vecs[5] = '{16'h0100, 32'h00010000};

    // Reset state, with start asserted to show it is ignored under reset.
    rst = 1'b0; start = 1'b1; a = 16'h0005;
    step(); step();
    check("reset result", 64'(result), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
`ifdef SQUARE_OVF_EN
    check("reset ovf", 64'(ovf), 64'd0);
`endif
    start = 1'b0;
    rst = 1'b1;
    step();
    check("idle after release", 64'(busy), 64'd0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));

    // Random operands against plain multiplication.
    for (int i = 0; i < 8; i++) begin
      r = WIDTH'($urandom);
      run_op(r, (2*WIDTH)'(longint'(r) * longint'(r)), $sformatf("rand%0d", i));
    end

    // start and A changes during CALC must be ignored.
    a = 16'h0003; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin a = 16'h00FF; start = 1'b1; end
      if (k == 6) start = 1'b0;
      step();
      if (done) pulses++;
    end
    check("ignored start pulses", 64'(pulses), 64'd1);
    check("ignored start result", 64'(result), 64'h9);
    check("ignored start busy", 64'(busy), 64'd0);

    // Leave ovf set (if present) so the reset below has something to clear.
    run_op(16'h0100, 32'h00010000, "pre_abort");

    // Reset mid-CALC aborts with no done pulse.
    a = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rst = 1'b0;
    #1;
    check("abort result", 64'(result), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
`ifdef SQUARE_OVF_EN
    check("abort ovf", 64'(ovf), 64'd0);
`endif
    step(); step();
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done || busy) pulses++;
    end
    check("abort no activity", 64'(pulses), 64'd0);
    run_op(16'h0010, 32'h00000100, "after_abort");

    // start held high: restart on the first IDLE edge after DONE, using A at that edge.
    a = 16'h0005; start = 1'b1;
    step();
    a = 16'h0007;
    pulses = 0;
    pulse_at[0] = 0; pulse_at[1] = 0;
    pulse_res[0] = '0; pulse_res[1] = '0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (done) begin
        pulse_at[pulses]  = k;
        pulse_res[pulses] = result;
        pulses++;
        if (pulses == 2) begin start = 1'b0; break; end
      end
    end
    check("held pulses", 64'(pulses), 64'd2);
    check("held first edge", 64'(pulse_at[0]), 64'd16);
    check("held first result", 64'(pulse_res[0]), 64'd25);
    check("held second edge", 64'(pulse_at[1]), 64'd34);
    check("held second result", 64'(pulse_res[1]), 64'd49);
    step();
    check("held end busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
